// File: rtl/alu_sel_a_decoder_if.sv
// Decoder-side bundle for the ALU operand-A select: stage enable and class code in,
// registered select and illegal-code flag out.
interface alu_sel_a_decoder_if #(
  parameter int CODE_W = 10
);
  logic              en;
  logic [CODE_W-1:0] code;
  logic              alu_sel_a;
  logic              code_err;

  modport master (
    output en,
    output code,
    input  alu_sel_a,
    input  code_err
  );

  modport slave (
    input  en,
    input  code,
    output alu_sel_a,
    output code_err
  );
endinterface

// File: rtl/alu_sel_a_decoder.sv
// RV32I operand-A select decoder: one-hot class code -> registered alu_sel_a (PC/CSR vs rs1).
// Optional one-hot checker compiled in with ALU_SEL_A_ONEHOT_CHECK_EN; otherwise code_err is tied 0.
module alu_sel_a_decoder #(
  parameter int CODE_W  = 10,
  parameter bit RST_SEL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_sel_a_decoder_if.slave bus
);

  // Classes whose operand A is the alternate source: J (bit 0), AUIPC (bit 3), CSR (bit 9).
  localparam logic [CODE_W-1:0] SEL_MASK = CODE_W'(10'b10_0000_1001);

  logic selD;
  logic selQ;

`ifdef ALU_SEL_A_ONEHOT_CHECK_EN
  localparam logic [CODE_W-1:0] CODE_ONE = CODE_W'(1);

  logic oneHot;
  logic errD;
  logic errQ;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  always_comb begin
    oneHot = (bus.code != '0) && ((bus.code & (bus.code - CODE_ONE)) == '0);
    selD   = 1'b0;
    errD   = 1'b1;
    if (oneHot) begin
      selD = |(bus.code & SEL_MASK);
      errD = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      selQ <= RST_SEL;
      errQ <= 1'b0;
    end else if (bus.en) begin
      selQ <= selD;
      errQ <= errD;
    end
  end

  assign bus.code_err = errQ;
`else
  // Without the checker, multi-hot codes fall through as the OR of per-bit selects.
  always_comb begin
    selD = |(bus.code & SEL_MASK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      selQ <= RST_SEL;
    end else if (bus.en) begin
      selQ <= selD;
    end
  end

  assign bus.code_err = 1'b0;
`endif

  assign bus.alu_sel_a = selQ;

endmodule

// File: tb/tb_alu_sel_a_decoder.sv
// Directed self-checking bench for alu_sel_a_decoder; expectations follow the
// ALU_SEL_A_ONEHOT_CHECK_EN setting the bench is compiled with.
module tb_alu_sel_a_decoder;

   logic clk;
   logic rst_n;
   int   checkCount;
   int   failCount;

   alu_sel_a_decoder_if #(.CODE_W(10)) bus ();

   alu_sel_a_decoder #(
      .CODE_W (10),
      .RST_SEL(1'b0)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic observed, input logic expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %b, expected %b at %0t", tag, observed, expected, $time);
      end
   endtask

   // Drive inputs on the falling edge, then land just after the next rising edge.
   task automatic applyStimulus(input logic [9:0] codeVal, input logic enVal);
      @(negedge clk);
      bus.code = codeVal;
      bus.en   = enVal;
      @(posedge clk);
      #1;
   endtask

   // Hand-computed select per one-hot position [0]..[9]: 1,0,0,1,0,0,0,0,0,1.
   logic [9:0] expSel;

   initial begin
      checkCount = 0;
      failCount  = 0;
      expSel     = 10'b10_0000_1001;

      // Reset asserted before any clock edge.
      rst_n    = 1'b0;
      bus.code = 10'b00_0000_0001;
      bus.en   = 1'b1;
      #2;
      checkOutput("reset_sel_noedge", bus.alu_sel_a, 1'b0);
      checkOutput("reset_err_noedge", bus.code_err, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("reset_sel_edge", bus.alu_sel_a, 1'b0);
      checkOutput("reset_err_edge", bus.code_err, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;

      // One-hot sweep.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(10'b1 << i, 1'b1);
         checkOutput($sformatf("sweep_sel_%0d", i), bus.alu_sel_a, expSel[i]);
         checkOutput($sformatf("sweep_err_%0d", i), bus.code_err, 1'b0);
      end

      // Stall holds the AUIPC select while an R-type code sits on the input.
      applyStimulus(10'b00_0000_1000, 1'b1);
      checkOutput("stall_pre", bus.alu_sel_a, 1'b1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(10'b00_0010_0000, 1'b0);
         checkOutput($sformatf("stall_hold_%0d", i), bus.alu_sel_a, 1'b1);
      end
      applyStimulus(10'b00_0010_0000, 1'b1);
      checkOutput("stall_release", bus.alu_sel_a, 1'b0);

`ifdef ALU_SEL_A_ONEHOT_CHECK_EN
      applyStimulus(10'b00_0000_0000, 1'b1);
      checkOutput("zero_sel", bus.alu_sel_a, 1'b0);
      checkOutput("zero_err", bus.code_err, 1'b1);
      applyStimulus(10'b10_0000_0001, 1'b1);
      checkOutput("multi_sel", bus.alu_sel_a, 1'b0);
      checkOutput("multi_err", bus.code_err, 1'b1);
      applyStimulus(10'b00_1000_0000, 1'b1);
      checkOutput("legal_sel", bus.alu_sel_a, 1'b0);
      checkOutput("legal_err", bus.code_err, 1'b0);
`else
      applyStimulus(10'b10_0001_0000, 1'b1);
      checkOutput("multi_or_sel", bus.alu_sel_a, 1'b1);
      checkOutput("multi_or_err", bus.code_err, 1'b0);
      applyStimulus(10'b00_0000_0000, 1'b1);
      checkOutput("zero_sel", bus.alu_sel_a, 1'b0);
      checkOutput("zero_err", bus.code_err, 1'b0);
      applyStimulus(10'b10_0000_0001, 1'b1);
      checkOutput("multi_sel", bus.alu_sel_a, 1'b1);
      checkOutput("multi_err", bus.code_err, 1'b0);
`endif

      // Asynchronous reset pulse between edges while the select is high.
      applyStimulus(10'b10_0000_0000, 1'b1);
      checkOutput("pulse_pre", bus.alu_sel_a, 1'b1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("pulse_async", bus.alu_sel_a, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("pulse_held", bus.alu_sel_a, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("pulse_released", bus.alu_sel_a, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("pulse_reload", bus.alu_sel_a, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
